// File: rtl/main_memory_responder_if.sv
// ============================================================================
// main_memory_responder_if
// Request/response bus between a memory initiator and main_memory_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface main_memory_responder_if #(
   parameter int SOURCE_W = 8
);
   logic                req_valid;
   logic                req_write;
   logic [31:0]         req_address;
   logic [SOURCE_W-1:0] req_source;
   logic [63:0]         req_data;
   logic                request_busy;
   logic                response_busy;
   logic                resp_accept;
   logic [63:0]         resp_payload;
   logic [SOURCE_W-1:0] resp_source;
   logic [31:0]         resp_address;
   logic                err_addr;
   logic                err_proto;

   modport master (
      output req_valid, req_write, req_address, req_source, req_data, resp_accept,
      input  request_busy, response_busy, resp_payload, resp_source, resp_address,
             err_addr, err_proto
   );

   modport slave (
      input  req_valid, req_write, req_address, req_source, req_data, resp_accept,
      output request_busy, response_busy, resp_payload, resp_source, resp_address,
             err_addr, err_proto
   );
endinterface

`default_nettype wire

// File: rtl/main_memory_responder.sv
// ============================================================================
// main_memory_responder
// Single-outstanding 64-bit word memory: posted writes, fixed-latency tagged
// read responses. Optional trace output under MAIN_MEMORY_TRACE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module main_memory_responder #(
   parameter int MEM_WORDS    = 1024,
   parameter int READ_LATENCY = 2,
   parameter int SOURCE_W     = 8
) (
   input  wire logic               clk,
   input  wire logic               reset,
   main_memory_responder_if.slave  bus
);
   localparam int          AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int          CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [32:0] C_LIMIT = 33'(MEM_WORDS) << 3;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WRITE_DONE = 2'd1,
      S_READ_WAIT  = 2'd2,
      S_RESPOND    = 2'd3
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [31:0]         r_addr;
   logic [SOURCE_W-1:0] r_source;
   logic                r_addr_ok;
   logic [63:0]         r_mem [MEM_WORDS];

   logic          w_addr_ok;
   logic [AW-1:0] w_idx;
   logic [AW-1:0] r_idx;
   logic [63:0]   w_rd_data;
   logic          w_accept;

   assign w_addr_ok = (bus.req_address[2:0] == 3'b000) && ({1'b0, bus.req_address} < C_LIMIT);
   assign w_idx     = bus.req_address[3 +: AW];
   assign r_idx     = r_addr[3 +: AW];
   assign w_rd_data = r_addr_ok ? r_mem[r_idx] : 64'd0;
   assign w_accept  = (r_state == S_IDLE) && bus.req_valid;

   assign bus.request_busy  = (r_state != S_IDLE);
   assign bus.response_busy = (r_state == S_RESPOND);

   // Storage has no reset: contents survive a responder reset.
   always_ff @(posedge clk) begin
      if (!reset && w_accept && bus.req_write && w_addr_ok) begin
         r_mem[w_idx] <= bus.req_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_addr           <= '0;
         r_source         <= '0;
         r_addr_ok        <= 1'b0;
         bus.resp_payload <= '0;
         bus.resp_source  <= '0;
         bus.resp_address <= '0;
         bus.err_addr     <= 1'b0;
         bus.err_proto    <= 1'b0;
      end else begin
         if ((bus.req_valid && r_state != S_IDLE) ||
             (bus.resp_accept && r_state != S_RESPOND)) begin
            bus.err_proto <= 1'b1;
`ifdef MAIN_MEMORY_TRACE_EN
            $display("mem protocol violation, state ", r_state);
`endif
         end
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_addr    <= bus.req_address;
                  r_source  <= bus.req_source;
                  r_addr_ok <= w_addr_ok;
                  if (!w_addr_ok) begin
                     bus.err_addr <= 1'b1;
`ifdef MAIN_MEMORY_TRACE_EN
                     $display("mem address error at ", bus.req_address);
`endif
                  end
                  if (bus.req_write) begin
                     r_state <= S_WRITE_DONE;
`ifdef MAIN_MEMORY_TRACE_EN
                     $display("mem write ", bus.req_data, " at ", bus.req_address,
                              " src ", bus.req_source);
`endif
                  end else begin
                     r_cnt   <= CNT_W'(READ_LATENCY - 1);
                     r_state <= S_READ_WAIT;
                  end
               end
            end
            S_WRITE_DONE: r_state <= S_IDLE;
            S_READ_WAIT: begin
               if (r_cnt == '0) begin
                  bus.resp_payload <= w_rd_data;
                  bus.resp_source  <= r_source;
                  bus.resp_address <= r_addr;
                  r_state          <= S_RESPOND;
`ifdef MAIN_MEMORY_TRACE_EN
                  $display("mem read ", w_rd_data, " at ", r_addr);
`endif
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESPOND: begin
               if (bus.resp_accept) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire
